// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, FSM state codes, mux selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    // Opcodes the controller understands (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    // Encodings are visible on state_o, so they are fixed rather than left to the tool
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    // ALU B operand select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // ALU operation select
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Next-PC source select
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Control word produced by the state decoder
    typedef struct packed {
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       branch;
        logic       pc_write;
        logic       instr_done;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle: decoded instruction fields and memory status in, control word out.
// Latency: n/a (wires only).
// Backpressure: mem_ready from memory stalls the controller in its memory states.
interface mips_multicycle_ctrl_if #(
    parameter int OPCODE_W = 6
);
    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                mem_ready;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          alu_op;
    logic [1:0]          pc_src;
    logic                branch;
    logic                pc_en;
    logic                instr_done;
    logic                illegal_op;
    logic [3:0]          state_o;

    // Controller side
    modport master (
        input  opcode, zero, mem_ready,
        output i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_src, branch, pc_en, instr_done,
               illegal_op, state_o
    );

    // Datapath / memory side
    modport slave (
        output opcode, zero, mem_ready,
        input  i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_src, branch, pc_en, instr_done,
               illegal_op, state_o
    );
endinterface

// File: rtl/mips_ctrl_decode.sv
// Moore decode of FSM state into the datapath control word.
// Latency: combinational, zero cycles.
// Backpressure: mem_ready only gates the FETCH loads and the MEMWR completion pulse.
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    // One control word per state; unused state codes fall through to all-zero
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.i_or_d     = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_op     = ALU_SUB;
                ctrl.pc_src     = PC_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src     = PC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS: fetch, decode, execute, memory, writeback.
// Latency: lw 5, sw/R-type/addi 4, beq/j 3 cycles; +1 per mem_ready=0 cycle in a memory state.
// Backpressure: FETCH, MEMRD and MEMWR hold with requests stable until mem_ready.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter bit MEM_WAIT = 1'b1,
    parameter int OPCODE_W = 6
) (
    input logic                    clk,
    input logic                    rst,
    mips_multicycle_ctrl_if.master bus
);

    state_t              state;
    state_t              state_nxt;
    ctrl_t               ctrl;
    logic                rdy;
    logic [OPCODE_W-1:0] op;
    logic                illegal;

    // With single-cycle memory the handshake is tied off
    assign rdy = MEM_WAIT ? bus.mem_ready : 1'b1;
    assign op  = bus.opcode;

    mips_ctrl_decode u_decode (
        .state     (state),
        .mem_ready (rdy),
        .ctrl      (ctrl)
    );

    // State register; reset abandons whatever instruction is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state sequencing; opcode comes from IR, so it is still valid after DECODE
    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OPCODE_W'(OP_RTYPE):             state_nxt = S_EXEC;
                    OPCODE_W'(OP_LW), OPCODE_W'(OP_SW): state_nxt = S_MEMADR;
                    OPCODE_W'(OP_BEQ):               state_nxt = S_BRANCH;
                    OPCODE_W'(OP_ADDI):              state_nxt = S_ADDIEX;
                    OPCODE_W'(OP_J):                 state_nxt = S_JUMP;
                    default:                         state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: state_nxt = (op == OPCODE_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_nxt = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_nxt = rdy ? S_FETCH : S_MEMWR;
            S_EXEC:   state_nxt = S_ALUWB;
            S_ADDIEX: state_nxt = S_ADDIWB;
            default:  state_nxt = S_FETCH;
        endcase
    end

    assign illegal = (state == S_DECODE) && !op_supported(6'(op));

    // Plain selects pass straight through; anything that commits state is held off during reset
    assign bus.i_or_d     = ctrl.i_or_d;
    assign bus.mem_read   = ctrl.mem_read;
    assign bus.reg_dst    = ctrl.reg_dst;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.alu_op     = ctrl.alu_op;
    assign bus.pc_src     = ctrl.pc_src;
    assign bus.branch     = ctrl.branch;
    assign bus.mem_write  = ctrl.mem_write & ~rst;
    assign bus.ir_write   = ctrl.ir_write & ~rst;
    assign bus.reg_write  = ctrl.reg_write & ~rst;
    assign bus.instr_done = ctrl.instr_done & ~rst;
    assign bus.pc_en      = (ctrl.pc_write | (ctrl.branch & bus.zero)) & ~rst;
    assign bus.illegal_op = illegal & ~rst;
    assign bus.state_o    = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed vector table, hand sequences, randomized run vs instruction-level model.
// Latency: n/a.
// Backpressure: mem_ready is driven per cycle by the bench.
module tb_mips_multicycle_ctrl;

    logic clk;
    logic rst;

    mips_multicycle_ctrl_if #(.OPCODE_W(6)) bus ();

    mips_multicycle_ctrl #(.MEM_WAIT(1'b1), .OPCODE_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output bit positions inside the packed observation vector
    localparam logic [17:0] IORD     = 18'h20000;
    localparam logic [17:0] MRD      = 18'h10000;
    localparam logic [17:0] MWR      = 18'h08000;
    localparam logic [17:0] IRW      = 18'h04000;
    localparam logic [17:0] RDST     = 18'h02000;
    localparam logic [17:0] M2R      = 18'h01000;
    localparam logic [17:0] RW       = 18'h00800;
    localparam logic [17:0] SRCA     = 18'h00400;
    localparam logic [17:0] SRCB_4   = 18'h00100;
    localparam logic [17:0] SRCB_IMM = 18'h00200;
    localparam logic [17:0] SRCB_SH  = 18'h00300;
    localparam logic [17:0] ALU_SUBF = 18'h00040;
    localparam logic [17:0] ALU_FN   = 18'h00080;
    localparam logic [17:0] PC_OUT   = 18'h00010;
    localparam logic [17:0] PC_JMP   = 18'h00020;
    localparam logic [17:0] BR       = 18'h00008;
    localparam logic [17:0] PCEN     = 18'h00004;
    localparam logic [17:0] DONE     = 18'h00002;
    localparam logic [17:0] ILL      = 18'h00001;
    localparam logic [17:0] FETCH_GO = MRD | SRCB_4 | IRW | PCEN;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rs;
        logic [5:0]  op;
        logic        z;
        logic        r;
        logic [3:0]  st;
        logic [17:0] ex;
    } vec_t;

    vec_t tv[$];

    // Instruction-level model state
    int         seq[$];
    int         idx;
    logic [5:0] cur_op;

    function automatic logic [17:0] outs();
        return {bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst,
                bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.pc_src, bus.branch, bus.pc_en, bus.instr_done, bus.illegal_op};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rs, input logic [5:0] op, input logic z, input logic r);
        rst           = rs;
        bus.opcode    = op;
        bus.zero      = z;
        bus.mem_ready = r;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic legal(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
    endfunction

    // Stage list an instruction walks through, in state_o numbering
    function automatic void new_instr();
        int pick;
        pick = $urandom_range(0, 7);
        case (pick)
            0: cur_op = 6'h00;
            1: cur_op = 6'h23;
            2: cur_op = 6'h2B;
            3: cur_op = 6'h04;
            4: cur_op = 6'h08;
            5: cur_op = 6'h02;
            default: cur_op = 6'($urandom_range(0, 63));
        endcase
        seq = '{0, 1};
        case (cur_op)
            6'h00: begin seq.push_back(6); seq.push_back(7); end
            6'h23: begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
            6'h2B: begin seq.push_back(2); seq.push_back(5); end
            6'h04: seq.push_back(8);
            6'h08: begin seq.push_back(9); seq.push_back(10); end
            6'h02: seq.push_back(11);
            default: ;
        endcase
        idx = 0;
    endfunction

    // Datapath steering of each stage, before completion/reset effects are applied
    function automatic logic [17:0] stage_outs(input int stg, input logic r, input logic z,
                                               input logic ill);
        case (stg)
            0:  return MRD | SRCB_4 | (r ? (IRW | PCEN) : 18'h0);
            1:  return SRCB_SH | (ill ? ILL : 18'h0);
            2:  return SRCA | SRCB_IMM;
            3:  return IORD | MRD;
            4:  return M2R | RW;
            5:  return IORD | MWR;
            6:  return SRCA | ALU_FN;
            7:  return RDST | RW;
            8:  return SRCA | ALU_SUBF | PC_OUT | BR | (z ? PCEN : 18'h0);
            9:  return SRCA | SRCB_IMM;
            10: return RW;
            11: return PC_JMP | PCEN;
            default: return 18'h0;
        endcase
    endfunction

    initial begin
        int nmw;
        int ndone;
        int done_cyc;
        int nbad;
        logic rr, zz, rs, last, adv;
        int stg;
        logic [17:0] ex;
        logic [17:0] o;
        logic r_sw[7];

        // Directed vectors: reset, lw, beq taken/not taken, j, fetch stall, R-type, addi
        tv.push_back('{1'b1, 6'h00, 1'b0, 1'b1, 4'd0,  MRD | SRCB_4});
        tv.push_back('{1'b1, 6'h00, 1'b0, 1'b1, 4'd0,  MRD | SRCB_4});
        tv.push_back('{1'b0, 6'h23, 1'b0, 1'b1, 4'd0,  FETCH_GO});
        tv.push_back('{1'b0, 6'h23, 1'b0, 1'b1, 4'd1,  SRCB_SH});
        tv.push_back('{1'b0, 6'h23, 1'b0, 1'b1, 4'd2,  SRCA | SRCB_IMM});
        tv.push_back('{1'b0, 6'h23, 1'b0, 1'b1, 4'd3,  IORD | MRD});
        tv.push_back('{1'b0, 6'h23, 1'b0, 1'b1, 4'd4,  M2R | RW | DONE});
        tv.push_back('{1'b0, 6'h04, 1'b1, 1'b1, 4'd0,  FETCH_GO});
        tv.push_back('{1'b0, 6'h04, 1'b1, 1'b1, 4'd1,  SRCB_SH});
        tv.push_back('{1'b0, 6'h04, 1'b1, 1'b1, 4'd8,  SRCA | ALU_SUBF | PC_OUT | BR | PCEN | DONE});
        tv.push_back('{1'b0, 6'h04, 1'b0, 1'b1, 4'd0,  FETCH_GO});
        tv.push_back('{1'b0, 6'h04, 1'b0, 1'b1, 4'd1,  SRCB_SH});
        tv.push_back('{1'b0, 6'h04, 1'b0, 1'b1, 4'd8,  SRCA | ALU_SUBF | PC_OUT | BR | DONE});
        tv.push_back('{1'b0, 6'h02, 1'b0, 1'b1, 4'd0,  FETCH_GO});
        tv.push_back('{1'b0, 6'h02, 1'b0, 1'b1, 4'd1,  SRCB_SH});
        tv.push_back('{1'b0, 6'h02, 1'b0, 1'b1, 4'd11, PC_JMP | PCEN | DONE});
        tv.push_back('{1'b0, 6'h00, 1'b0, 1'b0, 4'd0,  MRD | SRCB_4});
        tv.push_back('{1'b0, 6'h00, 1'b0, 1'b1, 4'd0,  FETCH_GO});
        tv.push_back('{1'b0, 6'h00, 1'b0, 1'b1, 4'd1,  SRCB_SH});
        tv.push_back('{1'b0, 6'h00, 1'b0, 1'b1, 4'd6,  SRCA | ALU_FN});
        tv.push_back('{1'b0, 6'h00, 1'b0, 1'b1, 4'd7,  RDST | RW | DONE});
        tv.push_back('{1'b0, 6'h08, 1'b0, 1'b1, 4'd0,  FETCH_GO});
        tv.push_back('{1'b0, 6'h08, 1'b0, 1'b1, 4'd1,  SRCB_SH});
        tv.push_back('{1'b0, 6'h08, 1'b0, 1'b1, 4'd9,  SRCA | SRCB_IMM});
        tv.push_back('{1'b0, 6'h08, 1'b0, 1'b1, 4'd10, RW | DONE});
        tv.push_back('{1'b0, 6'h00, 1'b0, 1'b0, 4'd0,  MRD | SRCB_4});

        rst           = 1'b1;
        bus.opcode    = 6'h00;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        tick();

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rs, tv[i].op, tv[i].z, tv[i].r);
            chk($sformatf("vec%0d_state", i), 32'(bus.state_o), 32'(tv[i].st));
            chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(tv[i].ex));
            tick();
        end

        // sw with three wait cycles in MEMWR: 7 cycles total, one completion pulse on the ready cycle
        r_sw = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        nmw = 0; ndone = 0; done_cyc = -1; nbad = 0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 6'h2B, 1'b0, r_sw[i]);
            if (bus.mem_write) begin
                nmw++;
                if (!bus.i_or_d || bus.mem_read) nbad++;
            end
            if (bus.instr_done) begin
                ndone++;
                done_cyc = i;
            end
            if (i == 3) chk("sw_wait_state", 32'(bus.state_o), 32'd5);
            tick();
        end
        chk("sw_mem_write_cycles", nmw, 4);
        chk("sw_iord_exclusive", nbad, 0);
        chk("sw_done_count", ndone, 1);
        chk("sw_done_cycle", done_cyc, 6);
        drive(1'b0, 6'h2B, 1'b0, 1'b0);
        chk("sw_back_to_fetch", 32'(bus.state_o), 32'd0);
        tick();

        // Illegal opcode: single pulse in DECODE, straight back to FETCH, nothing written
        nbad = 0; ndone = 0;
        drive(1'b0, 6'h3F, 1'b0, 1'b1);
        if (bus.reg_write || bus.mem_write) nbad++;
        if (bus.illegal_op) ndone++;
        tick();
        drive(1'b0, 6'h3F, 1'b0, 1'b1);
        chk("ill_decode_state", 32'(bus.state_o), 32'd1);
        chk("ill_pulse", 32'(bus.illegal_op), 32'd1);
        if (bus.reg_write || bus.mem_write) nbad++;
        tick();
        drive(1'b0, 6'h3F, 1'b0, 1'b0);
        chk("ill_next_fetch", 32'(bus.state_o), 32'd0);
        if (bus.reg_write || bus.mem_write) nbad++;
        if (bus.illegal_op) ndone++;
        chk("ill_no_writes", nbad, 0);
        chk("ill_no_extra_pulse", ndone, 0);
        tick();

        // Reset while lw waits in MEMRD: abandoned, no writeback, no completion
        nbad = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 6'h23, 1'b0, 1'b1);
            if (bus.reg_write || bus.instr_done) nbad++;
            tick();
        end
        drive(1'b0, 6'h23, 1'b0, 1'b0);
        chk("rstmid_in_memrd", 32'(bus.state_o), 32'd3);
        tick();
        drive(1'b1, 6'h23, 1'b0, 1'b0);
        o = outs();
        if (bus.reg_write || bus.instr_done) nbad++;
        chk("rstmid_gated", 32'(o & (IRW | PCEN | RW | MWR | DONE | ILL)), 32'd0);
        tick();
        drive(1'b0, 6'h23, 1'b0, 1'b0);
        chk("rstmid_fetch", 32'(bus.state_o), 32'd0);
        if (bus.reg_write || bus.instr_done) nbad++;
        chk("rstmid_no_wb", nbad, 0);
        tick();

        // Randomized run against the instruction-level model
        drive(1'b1, 6'h00, 1'b0, 1'b1);
        tick();
        new_instr();
        for (int c = 0; c < 1500; c++) begin
            rs = ($urandom_range(0, 39) == 0);
            rr = ($urandom_range(0, 3) != 0);
            zz = 1'($urandom_range(0, 1));
            drive(rs, cur_op, zz, rr);
            stg  = seq[idx];
            last = (idx == seq.size() - 1);
            adv  = !((stg == 0 || stg == 3 || stg == 5) && !rr);
            ex   = stage_outs(stg, rr, zz, !legal(cur_op));
            if (last && adv && legal(cur_op)) ex = ex | DONE;
            if (rs) ex = ex & ~(IRW | PCEN | RW | MWR | DONE | ILL);
            chk($sformatf("rand%0d_state", c), 32'(bus.state_o), 32'(stg));
            chk($sformatf("rand%0d_outs", c), 32'(outs()), 32'(ex));
            if (rs) begin
                new_instr();
            end else if (adv) begin
                idx++;
                if (idx == seq.size()) new_instr();
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
